// File: rtl/tm_pkg.sv
// tm_pkg: move and halt encodings plus the power-on rule program
// shared by the tm_engine Turing machine and its rule table.
package tm_pkg;

   localparam logic [1:0] MV_STAY  = 2'b00;
   localparam logic [1:0] MV_RIGHT = 2'b01;
   localparam logic [1:0] MV_LEFT  = 2'b10;

   localparam logic [1:0] HC_HALT  = 2'd0;
   localparam logic [1:0] HC_LEFT  = 2'd1;
   localparam logic [1:0] HC_RIGHT = 2'd2;
   localparam logic [1:0] HC_LIMIT = 2'd3;

   typedef struct packed {
      logic       halt;
      logic [1:0] nxt;
      logic       wsym;
      logic [1:0] mv;
   } def_rule_t;

   // unary-add program, indexed by {state, read_sym}
   function automatic def_rule_t def_rule(input int a);
      def_rule_t r;
      case (a)
         0:       r = '{1'b0, 2'd1, 1'b0, MV_RIGHT};
         1:       r = '{1'b0, 2'd0, 1'b0, MV_STAY};
         2:       r = '{1'b0, 2'd2, 1'b1, MV_STAY};
         3:       r = '{1'b0, 2'd1, 1'b1, MV_RIGHT};
         4:       r = '{1'b0, 2'd3, 1'b0, MV_LEFT};
         5:       r = '{1'b0, 2'd2, 1'b1, MV_RIGHT};
         6:       r = '{1'b1, 2'd3, 1'b0, MV_STAY};
         7:       r = '{1'b1, 2'd3, 1'b0, MV_STAY};
         default: r = '{1'b1, 2'd0, 1'b0, MV_STAY};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tm_rule_table.sv
// tm_rule_table: rule register file with one write port, one
// combinational read port, async reset to the default program.
module tm_rule_table
   import tm_pkg::*;
#(
   parameter int STATE_W = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [STATE_W:0]   waddr,
   input  logic [STATE_W+3:0] wdata,
   input  logic [STATE_W:0]   raddr,
   output logic [STATE_W+3:0] rdata
);

   localparam int N = 2 ** (STATE_W + 1);

   logic [STATE_W+3:0] mem [N];

   // entries beyond the built-in program halt and rewrite the read symbol
   function automatic logic [STATE_W+3:0] dflt(input int a);
      def_rule_t d;
      d = def_rule(a);
      if (a < 8)
         return {d.halt, STATE_W'(d.nxt), d.wsym, d.mv};
      return {1'b1, STATE_W'(a >> 1), a[0], MV_STAY};
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++)
            mem[i] <= dflt(i);
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tm_engine.sv
// tm_engine: single-tape binary Turing machine, one transition
// per clock, programmable rule table, reports why it halted.
module tm_engine
   import tm_pkg::*;
#(
   parameter  int TAPE_LEN  = 16,
   parameter  int STATE_W   = 2,
   parameter  int STEP_W    = 8,
   parameter  int MAX_STEPS = 255,
   localparam int HEAD_W    = $clog2(TAPE_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [TAPE_LEN-1:0] tape_in,
   input  logic [HEAD_W-1:0]   head_init,
   input  logic                rule_we,
   input  logic [STATE_W:0]    rule_addr,
   input  logic [STATE_W+3:0]  rule_data,
   output logic                busy,
   output logic                done,
   output logic [1:0]          halt_code,
   output logic [TAPE_LEN-1:0] tape_out,
   output logic [HEAD_W-1:0]   head_pos,
   output logic [STATE_W-1:0]  cur_state,
   output logic [STEP_W-1:0]   step_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

   fsm_t               fsm;
   logic [STATE_W+3:0] rd;
   logic               r_halt, r_wsym;
   logic [STATE_W-1:0] r_next;
   logic [1:0]         r_mv;
   logic               head_ok, sym;
   logic               go_l, go_r, at_l, at_r, last;
   logic               fin, mv_ok;
   logic [1:0]         hc;

   tm_rule_table #(.STATE_W(STATE_W)) u_tbl (
      .clk   (clk),
      .rst   (rst),
      .we    (rule_we & ~busy),
      .waddr (rule_addr),
      .wdata (rule_data),
      .raddr ({cur_state, sym}),
      .rdata (rd)
   );

   assign {r_halt, r_next, r_wsym, r_mv} = rd;

   assign head_ok = {1'b0, head_pos} < (HEAD_W + 1)'(TAPE_LEN);
   assign sym     = head_ok ? tape_out[head_pos] : 1'b0;
   assign go_l    = r_mv == MV_LEFT;
   assign go_r    = r_mv == MV_RIGHT;
   assign at_l    = head_pos == '0;
   assign at_r    = head_pos == HEAD_W'(TAPE_LEN - 1);
   assign last    = step_cnt == STEP_W'(MAX_STEPS - 1);

   // halt sources in priority order; a bad start head takes no step
   always_comb begin
      fin   = 1'b1;
      hc    = HC_HALT;
      mv_ok = 1'b0;
      if (!head_ok)          hc = HC_RIGHT;
      else if (r_halt)       hc = HC_HALT;
      else if (go_l && at_l) hc = HC_LEFT;
      else if (go_r && at_r) hc = HC_RIGHT;
      else begin
         mv_ok = 1'b1;
         if (last) hc = HC_LIMIT;
         else      fin = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         halt_code <= '0;
         tape_out  <= '0;
         head_pos  <= '0;
         cur_state <= '0;
         step_cnt  <= '0;
      end else begin
         case (fsm)
            S_IDLE, S_DONE: begin
               if (start) begin
                  fsm       <= S_RUN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  halt_code <= '0;
                  tape_out  <= tape_in;
                  head_pos  <= head_init;
                  cur_state <= '0;
                  step_cnt  <= '0;
               end
            end
            S_RUN: begin
               if (head_ok) begin
                  tape_out[head_pos] <= r_wsym;
                  cur_state          <= r_next;
                  step_cnt           <= step_cnt + STEP_W'(1);
               end
               if (mv_ok && go_l) head_pos <= head_pos - HEAD_W'(1);
               if (mv_ok && go_r) head_pos <= head_pos + HEAD_W'(1);
               if (fin) begin
                  fsm       <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  halt_code <= hc;
               end
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

endmodule
